// File: rtl/alu_cmd_driver_if.sv
// Command and response streams between an initiator and alu_cmd_driver.
// Both streams are valid/ready: a transfer happens on a rising edge where valid && ready; once valid is raised the payload holds until that edge.
interface alu_cmd_driver_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Queues tagged ALU commands, issues them one at a time to a registered ALU and returns in-order responses.
// Optional result/zero consistency checker enabled by defining ALU_DRIVER_CHECK_EN.
module alu_cmd_driver #(
  parameter int CMD_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_cmd_driver_if.slave bus,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [3:0]    alu_op,
  input  logic [31:0]   alu_result,
  input  logic          alu_zero,
  output logic          busy,
`ifdef ALU_DRIVER_CHECK_EN
  output logic          chk_fail,
`endif
  output logic [2:0]    state_dbg
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RES,
    S_WAIT_ZERO,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem [CMD_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             push, pop, fifo_empty;
  logic             cmd_ready_q;

  state_t           state, state_next;
  logic             load_legal, load_illegal;

  logic [31:0]      rsp_result_q;
  logic             rsp_zero_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign push       = bus.cmd_valid && cmd_ready_q;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (!push && pop) count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};
  end

  // Ready is registered from the next count, so a pop while full only frees the slot next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_next;
      cmd_ready_q <= (count_next != CNT_W'(CMD_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    load_legal   = 1'b0;
    load_illegal = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.op[3]) begin
            load_illegal = 1'b1;
            state_next   = S_RESP;
          end else begin
            load_legal = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE:     state_next = S_WAIT_RES;
      S_WAIT_RES:  state_next = S_WAIT_ZERO;
      S_WAIT_ZERO: state_next = S_RESP;
      S_RESP:      if (bus.rsp_ready) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // The ALU zero flag trails its result by one cycle, hence the two capture states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_DRIVER_CHECK_EN
      chk_fail     <= 1'b0;
`endif
    end else begin
      if (load_legal) begin
        alu_a     <= head.a;
        alu_b     <= head.b;
        alu_op    <= head.op;
        rsp_tag_q <= head.tag;
        rsp_err_q <= 1'b0;
      end
      if (load_illegal) begin
        rsp_result_q <= '0;
        rsp_zero_q   <= 1'b1;
        rsp_err_q    <= 1'b1;
        rsp_tag_q    <= head.tag;
      end
      if (state == S_WAIT_RES) rsp_result_q <= alu_result;
      if (state == S_WAIT_ZERO) begin
        rsp_zero_q <= alu_zero;
`ifdef ALU_DRIVER_CHECK_EN
        if (alu_zero != (rsp_result_q == 32'd0)) begin
          rsp_err_q <= 1'b1;
          chk_fail  <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state != S_IDLE) || !fifo_empty;
  assign state_dbg      = state;
endmodule
